reducer7_3: RTL and testbench
=============================

REDUCER7_3 -- requirements
Module: reducer7_3

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; all widths below derive from it.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: a  input  WIDTH  operand 0.
REQ-005 Port: b  input  WIDTH  operand 1.
REQ-006 Port: c  input  WIDTH  operand 2.
REQ-007 Port: d  input  WIDTH  operand 3.
REQ-008 Port: e  input  WIDTH  operand 4.
REQ-009 Port: f  input  WIDTH  operand 5.
REQ-010 Port: g  input  WIDTH  operand 6.
REQ-011 Port: res3  output  WIDTH+2  weight-4 partial-sum vector, registered.
REQ-012 Port: res2  output  WIDTH+1  weight-2 partial-sum vector, registered.
REQ-013 Port: res1  output  WIDTH  weight-1 partial-sum vector, registered.
REQ-014 Port: done  output  1  result-valid flag, registered.
REQ-015 Positional port order SHALL be: a, b, c, d, e, f, g, res3, res2, res1, done, clk, rst.

Function
REQ-016 Block SHALL be a 7:3 column compressor: for each bit i in 0..WIDTH-1, count n_i = number of ones among a[i]..g[i] (0..7), as 3 bits {n2,n1,n0}.
REQ-017 Next res1[i] SHALL be n0 of column i, for i = 0..WIDTH-1.
REQ-018 Next res2[i+1] SHALL be n1 of column i; res2[0] SHALL always be 0.
REQ-019 Next res3[i+2] SHALL be n2 of column i; res3[1:0] SHALL always be 0.
REQ-020 Invariant: zero-extended res1+res2+res3 SHALL equal zero-extended a+b+c+d+e+f+g exactly (no truncation; max sum 7*(2^WIDTH-1) fits WIDTH+3 bits).
REQ-021 No carry propagation between columns SHALL occur inside the block; each output bit depends only on one input column.
REQ-022 Latency SHALL be one cycle: inputs sampled at rising edge k appear on res1/res2/res3 after edge k; block accepts new operands every cycle.
REQ-023 Inputs need not be registered; they SHALL be stable setup-before the sampling edge.
REQ-024 done SHALL go to 1 at the first rising edge with rst low and remain 1 until next reset; no start/handshake input exists.
REQ-025 Outputs SHALL hold their value between edges; no combinational path from inputs to outputs.

Reset
REQ-026 While rst is 1, res1, res2, res3 SHALL be all-zero and done SHALL be 0, asynchronously, independent of clk.
REQ-027 Reset asserted mid-stream SHALL clear outputs immediately; the in-flight sample is discarded.
REQ-028 After rst deasserts, the first rising edge SHALL load the reduction of current inputs and set done to 1.

Verification
REQ-029 Reset: rst=1 with arbitrary nonzero inputs -> res1=0, res2=0, res3=0, done=0 with no clock edge.
REQ-030 All operands 0, one edge after reset -> res1=0, res2=0, res3=0, done=1.
REQ-031 a=1, b..g=0 -> res1=0x00000001, res2=0, res3=0; a=b=c=1, rest 0 -> res1=0x1, res2=0x2, res3=0.
REQ-032 All seven operands 0xFFFFFFFF -> res1=0xFFFFFFFF, res2=0x1FFFFFFFE, res3=0x3FFFFFFFC; sum 0x6FFFFFFF9.
REQ-033 256 consecutive random 7-operand vectors, one per cycle -> each cycle, 64-bit res1+res2+res3 equals 64-bit sum of the operands applied one edge earlier; any mismatch fails.
REQ-034 Assert rst for one partial cycle during random stream -> outputs and done clear instantly, done returns 1 on first edge after release, results correct thereafter.

Source files
------------

// File: rtl/reducer7_3.sv
// reducer7_3: registered 7:3 column compressor.
//
// Every bit column i of the seven operands is reduced independently to its
// 3-bit population count {n2, n1, n0}. The count bits are placed at their
// arithmetic weights so that res1 + res2 + res3 equals the exact sum of the
// seven operands. There is no carry between columns. All outputs are
// registered, with a latency of one cycle and a throughput of one vector per
// cycle.
//
// Ports:
//   a..g  in   WIDTH    operands 0..6
//   res3  out  WIDTH+2  weight-4 vector; bit i+2 holds n2 of column i
//   res2  out  WIDTH+1  weight-2 vector; bit i+1 holds n1 of column i
//   res1  out  WIDTH    weight-1 vector; bit i holds n0 of column i
//   done  out  1        set by the first edge after reset, then held
//   clk   in   1        rising-edge clock
//   rst   in   1        asynchronous active-high reset

module reducer7_3 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH+1:0] res3,
    output logic [WIDTH:0]   res2,
    output logic [WIDTH-1:0] res1,
    output logic             done,
    input  logic             clk,
    input  logic             rst
);

    logic [WIDTH+1:0] res3_d, res3_q;
    logic [WIDTH:0]   res2_d, res2_q;
    logic [WIDTH-1:0] res1_d, res1_q;
    logic             done_d, done_q;

    // Per-column population count. The low bits of res2 and res3 have no
    // source column, so they stay at their zero default.
    always_comb begin
        logic [2:0] cnt;
        cnt    = '0;
        res1_d = '0;
        res2_d = '0;
        res3_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt = {2'b00, a[i]} + {2'b00, b[i]} + {2'b00, c[i]} + {2'b00, d[i]}
                + {2'b00, e[i]} + {2'b00, f[i]} + {2'b00, g[i]};
            res1_d[i]     = cnt[0];
            res2_d[i + 1] = cnt[1];
            res3_d[i + 2] = cnt[2];
        end
    end

    // After reset, every edge produces a valid result.
    always_comb begin
        done_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res1_q <= '0;
            res2_q <= '0;
            res3_q <= '0;
            done_q <= 1'b0;
        end else begin
            res1_q <= res1_d;
            res2_q <= res2_d;
            res3_q <= res3_d;
            done_q <= done_d;
        end
    end

    assign res1 = res1_q;
    assign res2 = res2_q;
    assign res3 = res3_q;
    assign done = done_q;

endmodule

// File: tb/tb_reducer7_3.sv
module tb_reducer7_3;

    localparam int unsigned W      = 32;
    localparam int          NRAND  = 256;
    localparam int          NDIR   = 4;
    localparam int          RST_AT = NDIR + 120;

    typedef struct packed {
        logic [W-1:0] r1;
        logic [W:0]   r2;
        logic [W+1:0] r3;
        logic [63:0]  sum;
    } exp_t;

    logic [W-1:0] a, b, c, d, e, f, g;
    logic [W+1:0] res3;
    logic [W:0]   res2;
    logic [W-1:0] res1;
    logic         done;
    logic         clk;
    logic         rst;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    bit   stop_mon;

    reducer7_3 #(.WIDTH(W)) dut (
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .e    (e),
        .f    (f),
        .g    (g),
        .res3 (res3),
        .res2 (res2),
        .res1 (res1),
        .done (done),
        .clk  (clk),
        .rst  (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count the ones in each column and put the count bits
    // at weights 1, 2 and 4. The plain 64-bit sum is kept for the invariant.
    function automatic exp_t model(input logic [6:0][W-1:0] ops);
        exp_t x;
        x = '0;
        for (int i = 0; i < int'(W); i++) begin
            int n;
            n = 0;
            for (int k = 0; k < 7; k++) n += int'(ops[k][i]);
            x.r1[i]     = (n % 2) == 1;
            x.r2[i + 1] = ((n / 2) % 2) == 1;
            x.r3[i + 2] = n >= 4;
        end
        for (int k = 0; k < 7; k++) x.sum += 64'(ops[k]);
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [6:0][W-1:0] ops);
        a = ops[0]; b = ops[1]; c = ops[2]; d = ops[3];
        e = ops[4]; f = ops[5]; g = ops[6];
        exp_q.push_back(model(ops));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_res1"}, 64'(res1), 64'd0);
        check({tag, "_res2"}, 64'(res2), 64'd0);
        check({tag, "_res3"}, 64'(res3), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    function automatic logic [6:0][W-1:0] rand_ops();
        logic [6:0][W-1:0] ops;
        for (int k = 0; k < 7; k++) ops[k] = $urandom;
        return ops;
    endfunction

    // Monitor: every cycle with a valid result consumes one expected entry.
    always @(negedge clk) begin
        if (!stop_mon && !rst && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: result present, no expected entry");
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("res1", 64'(res1), 64'(x.r1));
                check("res2", 64'(res2), 64'(x.r2));
                check("res3", 64'(res3), 64'(x.r3));
                check("sum", 64'(res1) + 64'(res2) + 64'(res3), x.sum);
            end
        end
    end

    initial begin
        logic [6:0][W-1:0] ops;
        bit chk_done;
        n_checks = 0;
        n_fail   = 0;
        stop_mon = 1'b0;
        chk_done = 1'b0;
        rst      = 1'b0;
        ops      = rand_ops();
        ops[0]   = ops[0] | 32'h1;
        a = ops[0]; b = ops[1]; c = ops[2]; d = ops[3];
        e = ops[4]; f = ops[5]; g = ops[6];

        // Reset takes effect with no clock edge and holds across edges.
        #1 rst = 1'b1;
        #1 check_cleared("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1 check_cleared("rst_held");

        for (int idx = 0; idx < NDIR + NRAND; idx++) begin
            if (idx > 0) begin
                @(posedge clk);
                #1;
            end
            if (chk_done) begin
                check("done_after_release", 64'(done), 64'd1);
                chk_done = 1'b0;
            end
            case (idx)
                0: ops = '0;
                1: begin ops = '0; ops[0] = 32'h1; end
                2: begin ops = '0; ops[0] = 32'h1; ops[1] = 32'h1; ops[2] = 32'h1; end
                3: for (int k = 0; k < 7; k++) ops[k] = 32'hFFFF_FFFF;
                default: ops = rand_ops();
            endcase
            drive(ops);
            if (idx == 0) begin
                rst      = 1'b0;
                chk_done = 1'b1;
            end
            if (idx == RST_AT) begin
                // Pulse reset inside one cycle; the pending sample is lost.
                #1 rst = 1'b1;
                #1 check_cleared("rst_midstream");
                exp_q.delete();
                #1 rst = 1'b0;
                drive(rand_ops());
                chk_done = 1'b1;
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1 stop_mon = 1'b1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
